// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run-control stage that gates the
// processor core with a single-cycle clock enable.
package run_ctrl_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int ADDR_W    = 16;

  typedef enum logic [1:0] {
    RS_RUN   = 2'd0,
    RS_BREAK = 2'd1,
    RS_HALT  = 2'd2
  } run_state_t;

endpackage

// File: rtl/run_ctrl_if.sv
// Board-side controls and debug outputs of run_ctrl, bundled for port use.
interface run_ctrl_if #(
  parameter int CNT_W = 16
);
  import run_ctrl_pkg::*;

  logic              manual;
  logic              step_btn;
  logic              tick;
  logic              resume;
  logic              hlt;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic [ADDR_W-1:0] pc;
  logic              proc_en;
  logic              exec;
  logic              run;
  logic              brk;
  logic [CNT_W-1:0]  cycle_cnt;

  modport master (
    output manual, step_btn, tick, resume, hlt, bp_en, bp_addr, pc,
    input  proc_en, exec, run, brk, cycle_cnt
  );

  modport slave (
    input  manual, step_btn, tick, resume, hlt, bp_en, bp_addr, pc,
    output proc_en, exec, run, brk, cycle_cnt
  );

endinterface

// File: rtl/run_ctrl_edge_rise.sv
// One-bit rising-edge detector. History resets high so a level already
// asserted while clr is low never produces a rise.
module edge_rise (
  input  logic clk,
  input  logic clr,
  input  logic level,
  output logic rise
);

  logic hist;

  always_ff @(posedge clk) begin
    if (!clr) hist <= 1'b1;
    else      hist <= level;
  end

  assign rise = level & ~hist;

endmodule

// File: rtl/run_ctrl.sv
// Run control: turns step-button / prescaler rises into one-cycle processor
// enables, qualified by halt and a PC breakpoint, and counts enabled cycles.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input logic       clk,
  input logic       clr,
  run_ctrl_if.slave bus
);

  logic             step_rise;
  logic             tick_rise;
  logic             resume_rise;
  logic             src_rise;
  logic             bp_hit;

  run_state_t       state;
  run_state_t       state_nxt;
  logic             pen_nxt;
  logic             skip_set;

  logic             proc_en;
  logic             exec;
  logic             skip;
  logic [CNT_W-1:0] cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  edge_rise u_step   (.clk(clk), .clr(clr), .level(bus.step_btn), .rise(step_rise));
  edge_rise u_tick   (.clk(clk), .clr(clr), .level(bus.tick),     .rise(tick_rise));
  edge_rise u_resume (.clk(clk), .clr(clr), .level(bus.resume),   .rise(resume_rise));

  // Mode only selects which rise counts, so switching it cannot fabricate a pulse.
  assign src_rise = bus.manual ? step_rise : tick_rise;
  assign bp_hit   = bus.bp_en & (bus.pc == bus.bp_addr) & ~skip;

  always_ff @(posedge clk) begin
    if (!clr) state <= RS_RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pen_nxt   = 1'b0;
    skip_set  = 1'b0;
    case (state)
      RS_RUN: begin
        if (bus.hlt)       state_nxt = RS_HALT;
        else if (bp_hit)   state_nxt = RS_BREAK;
        else if (src_rise) pen_nxt   = 1'b1;
      end
      RS_BREAK: begin
        if (bus.hlt) begin
          state_nxt = RS_HALT;
        end else if (resume_rise) begin
          state_nxt = RS_RUN;
          skip_set  = 1'b1;
          pen_nxt   = src_rise;
        end
      end
      RS_HALT: state_nxt = RS_HALT;
      default: state_nxt = RS_RUN;
    endcase
  end

  always_comb begin
    bus.run = (state == RS_RUN);
    bus.brk = (state == RS_BREAK);
  end

  // skip holds off a re-break on the resumed PC until that instruction executes.
  always_ff @(posedge clk) begin
    if (!clr) begin
      proc_en <= 1'b0;
      exec    <= 1'b1;
      skip    <= 1'b0;
      cnt     <= '0;
    end else begin
      proc_en <= pen_nxt;
      if (proc_en) exec <= 1'b0;
      if (skip_set)     skip <= 1'b1;
      else if (proc_en) skip <= 1'b0;
      if (proc_en) cnt <= sat_inc(cnt);
    end
  end

  assign bus.proc_en   = proc_en;
  assign bus.exec      = exec;
  assign bus.cycle_cnt = cnt;

endmodule
